// File: rtl/n2_issue_sched_pkg.sv
// Shared types for the N2 dual-issue scheduler: queue entry layout and defaults.
// Pure declarations; no timing or flow-control behaviour lives here.
package n2_issue_sched_pkg;

  localparam int REGINDEX_BITS = 5;
  localparam int IQ_DEPTH_DEF  = 4;
  localparam int UID_W         = 8;

  typedef logic [REGINDEX_BITS-1:0] reg_idx_t;

  typedef struct packed {
    logic [UID_W-1:0] uid;
    reg_idx_t         rd;
    reg_idx_t         rs1;
    reg_idx_t         rs2;
    logic             use_rs1;
    logic             use_rs2;
    logic             is_long;
    logic             is_ctrl;
  } iq_entry_t;

  // True when either used source of a uop names register r.
  function automatic logic src_match(input logic use_rs1, input reg_idx_t rs1,
                                     input logic use_rs2, input reg_idx_t rs2,
                                     input reg_idx_t r);
    return (use_rs1 && (rs1 == r)) || (use_rs2 && (rs2 == r));
  endfunction

endpackage

// File: rtl/n2_issue_sched_if.sv
// Decode-to-execute bundle around the issue scheduler; master drives decode/execute
// status, slave (the scheduler) returns ready, lane issues and scoreboard state.
interface n2_issue_sched_if
  import n2_issue_sched_pkg::*;
#(
  parameter int REGIDX_W = REGINDEX_BITS
);
  logic [1:0]                dec_v_i;
  logic [1:0][UID_W-1:0]     dec_uid_i;
  logic [1:0][REGIDX_W-1:0]  dec_rd_i;
  logic [1:0][REGIDX_W-1:0]  dec_rs1_i;
  logic [1:0][REGIDX_W-1:0]  dec_rs2_i;
  logic [1:0]                dec_use_rs1_i;
  logic [1:0]                dec_use_rs2_i;
  logic [1:0]                dec_long_i;
  logic [1:0]                dec_ctrl_i;
  logic                      dec_rdy_o;
  logic                      ex_stall_i;
  logic                      flush_i;
  logic                      wb_v_i;
  logic [REGIDX_W-1:0]       wb_rd_i;
  logic                      iss0_v_o;
  logic                      iss1_v_o;
  logic [UID_W-1:0]          iss0_uid_o;
  logic [UID_W-1:0]          iss1_uid_o;
  logic [2**REGIDX_W-1:0]    sb_busy_o;

  modport master (
    output dec_v_i, dec_uid_i, dec_rd_i, dec_rs1_i, dec_rs2_i,
           dec_use_rs1_i, dec_use_rs2_i, dec_long_i, dec_ctrl_i,
           ex_stall_i, flush_i, wb_v_i, wb_rd_i,
    input  dec_rdy_o, iss0_v_o, iss1_v_o, iss0_uid_o, iss1_uid_o, sb_busy_o
  );

  modport slave (
    input  dec_v_i, dec_uid_i, dec_rd_i, dec_rs1_i, dec_rs2_i,
           dec_use_rs1_i, dec_use_rs2_i, dec_long_i, dec_ctrl_i,
           ex_stall_i, flush_i, wb_v_i, wb_rd_i,
    output dec_rdy_o, iss0_v_o, iss1_v_o, iss0_uid_o, iss1_uid_o, sb_busy_o
  );

endinterface

// File: rtl/n2_issue_sched_scoreboard.sv
// Busy-register scoreboard for long-latency destinations; set/clear visible next cycle,
// lookups are combinational on the current state. No backpressure; set wins over clear.
module n2_scoreboard
  import n2_issue_sched_pkg::*;
#(
  parameter int REGIDX_W = REGINDEX_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   set_vld_i,
  input  logic [REGIDX_W-1:0]    set_idx_i,
  input  logic                   clr_vld_i,
  input  logic [REGIDX_W-1:0]    clr_idx_i,
  input  logic                   lk0_use_rs1_i,
  input  logic [REGIDX_W-1:0]    lk0_rs1_i,
  input  logic                   lk0_use_rs2_i,
  input  logic [REGIDX_W-1:0]    lk0_rs2_i,
  output logic                   lk0_busy_o,
  input  logic                   lk1_use_rs1_i,
  input  logic [REGIDX_W-1:0]    lk1_rs1_i,
  input  logic                   lk1_use_rs2_i,
  input  logic [REGIDX_W-1:0]    lk1_rs2_i,
  output logic                   lk1_busy_o,
  output logic [2**REGIDX_W-1:0] busy_o
);

  logic [2**REGIDX_W-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_vld_i) busy_d[clr_idx_i] = 1'b0;
    if (set_vld_i) busy_d[set_idx_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign lk0_busy_o = (lk0_use_rs1_i && busy_q[lk0_rs1_i]) ||
                      (lk0_use_rs2_i && busy_q[lk0_rs2_i]);
  assign lk1_busy_o = (lk1_use_rs1_i && busy_q[lk1_rs1_i]) ||
                      (lk1_use_rs2_i && busy_q[lk1_rs2_i]);
  assign busy_o     = busy_q;

endmodule

// File: rtl/n2_issue_sched.sv
// In-order dual-issue scheduler: uop queue plus hazard checks, 1-cycle head-to-issue latency.
// Decode is accepted only while two slots are free; ex_stall_i/flush_i hold or empty the queue.
module n2_issue_sched
  import n2_issue_sched_pkg::*;
#(
  parameter int QDEPTH   = IQ_DEPTH_DEF,
  parameter int REGIDX_W = REGINDEX_BITS
) (
  input logic             clk,
  input logic             rst,
  n2_issue_sched_if.slave bus
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 2**REGIDX_W;

  iq_entry_t          mem_q [QDEPTH];
  iq_entry_t          mem_d [QDEPTH];
  iq_entry_t          dec_ent [2];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   h1_ptr;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               dec_rdy_q, dec_rdy_d;
  logic               iss0_v_q, iss0_v_d, iss1_v_q, iss1_v_d;
  logic [UID_W-1:0]   iss0_uid_q, iss0_uid_d, iss1_uid_q, iss1_uid_d;
  logic               h_vld, h1_vld, h_src_busy, h1_src_busy, h_waw, raw_hit;
  logic               iss0_go, iss1_go, enq0, enq1, sb_set_vld;
  logic [1:0]         n_enq, n_iss;
  logic [NREG-1:0]    busy;

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      dec_ent[s] = '{uid:     bus.dec_uid_i[s],
                     rd:      bus.dec_rd_i[s],
                     rs1:     bus.dec_rs1_i[s],
                     rs2:     bus.dec_rs2_i[s],
                     use_rs1: bus.dec_use_rs1_i[s],
                     use_rs2: bus.dec_use_rs2_i[s],
                     is_long: bus.dec_long_i[s],
                     is_ctrl: bus.dec_ctrl_i[s]};
    end
  end

  assign h1_ptr = rd_ptr_q + PTR_W'(1);
  assign h_vld  = (count_q != '0);
  assign h1_vld = (count_q >= CNT_W'(2));

  n2_scoreboard #(.REGIDX_W(REGIDX_W)) u_sb (
    .clk           (clk),
    .rst           (rst),
    .set_vld_i     (sb_set_vld),
    .set_idx_i     (mem_q[rd_ptr_q].rd),
    .clr_vld_i     (bus.wb_v_i),
    .clr_idx_i     (bus.wb_rd_i),
    .lk0_use_rs1_i (mem_q[rd_ptr_q].use_rs1),
    .lk0_rs1_i     (mem_q[rd_ptr_q].rs1),
    .lk0_use_rs2_i (mem_q[rd_ptr_q].use_rs2),
    .lk0_rs2_i     (mem_q[rd_ptr_q].rs2),
    .lk0_busy_o    (h_src_busy),
    .lk1_use_rs1_i (mem_q[h1_ptr].use_rs1),
    .lk1_rs1_i     (mem_q[h1_ptr].rs1),
    .lk1_use_rs2_i (mem_q[h1_ptr].use_rs2),
    .lk1_rs2_i     (mem_q[h1_ptr].rs2),
    .lk1_busy_o    (h1_src_busy),
    .busy_o        (busy)
  );

  // A long op must not re-target a register whose earlier long write is still pending.
  assign h_waw   = mem_q[rd_ptr_q].is_long && busy[mem_q[rd_ptr_q].rd];
  assign raw_hit = (mem_q[rd_ptr_q].rd != '0) &&
                   src_match(mem_q[h1_ptr].use_rs1, mem_q[h1_ptr].rs1,
                             mem_q[h1_ptr].use_rs2, mem_q[h1_ptr].rs2,
                             mem_q[rd_ptr_q].rd);

  assign iss0_go = h_vld && !bus.ex_stall_i && !bus.flush_i && !h_src_busy && !h_waw;
  assign iss1_go = iss0_go && h1_vld &&
                   !mem_q[h1_ptr].is_long && !mem_q[h1_ptr].is_ctrl &&
                   !mem_q[rd_ptr_q].is_ctrl && !raw_hit && !h1_src_busy;

  assign sb_set_vld = iss0_go && mem_q[rd_ptr_q].is_long && (mem_q[rd_ptr_q].rd != '0);

  assign enq0  = dec_rdy_q && !bus.flush_i && bus.dec_v_i[0];
  assign enq1  = dec_rdy_q && !bus.flush_i && bus.dec_v_i[1];
  assign n_enq = {1'b0, enq0} + {1'b0, enq1};
  assign n_iss = {1'b0, iss0_go} + {1'b0, iss1_go};

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + PTR_W'(n_enq);
    rd_ptr_d = rd_ptr_q + PTR_W'(n_iss);
    count_d  = count_q + CNT_W'(n_enq) - CNT_W'(n_iss);
    if (enq0) mem_d[wr_ptr_q] = dec_ent[0];
    if (enq1) mem_d[wr_ptr_q + PTR_W'(enq0)] = dec_ent[1];
    if (bus.flush_i) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
      wr_ptr_d = wr_ptr_q;
    end
    // Ready means room for a full decode pair, judged on next cycle's occupancy.
    dec_rdy_d = (count_d <= CNT_W'(QDEPTH - 2));
  end

  always_comb begin
    iss0_v_d   = iss0_go;
    iss1_v_d   = iss1_go;
    iss0_uid_d = iss0_go ? mem_q[rd_ptr_q].uid : '0;
    iss1_uid_d = iss1_go ? mem_q[h1_ptr].uid   : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q      <= '{default: '0};
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      dec_rdy_q  <= 1'b1;
      iss0_v_q   <= 1'b0;
      iss1_v_q   <= 1'b0;
      iss0_uid_q <= '0;
      iss1_uid_q <= '0;
    end else begin
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      dec_rdy_q  <= dec_rdy_d;
      iss0_v_q   <= iss0_v_d;
      iss1_v_q   <= iss1_v_d;
      iss0_uid_q <= iss0_uid_d;
      iss1_uid_q <= iss1_uid_d;
    end
  end

  assign bus.dec_rdy_o  = dec_rdy_q;
  assign bus.iss0_v_o   = iss0_v_q;
  assign bus.iss1_v_o   = iss1_v_q;
  assign bus.iss0_uid_o = iss0_uid_q;
  assign bus.iss1_uid_o = iss1_uid_q;
  assign bus.sb_busy_o  = busy;

endmodule

// File: tb/tb_n2_issue_sched.sv
// Directed bench for n2_issue_sched: expected issue uids are queued at drive time
// and popped in order as the lanes report issues.
module tb_n2_issue_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  n2_issue_sched_if #(.REGIDX_W(5)) bus ();

  n2_issue_sched #(.QDEPTH(4), .REGIDX_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.dec_v_i       = '0;
    bus.dec_uid_i     = '0;
    bus.dec_rd_i      = '0;
    bus.dec_rs1_i     = '0;
    bus.dec_rs2_i     = '0;
    bus.dec_use_rs1_i = '0;
    bus.dec_use_rs2_i = '0;
    bus.dec_long_i    = '0;
    bus.dec_ctrl_i    = '0;
    bus.flush_i       = 1'b0;
    bus.wb_v_i        = 1'b0;
    bus.wb_rd_i       = '0;
  endtask

  task automatic put(input int s, input logic [7:0] uid, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic lng, input logic ctl,
                     input bit exp_iss);
    bus.dec_v_i[s]       = 1'b1;
    bus.dec_uid_i[s]     = uid;
    bus.dec_rd_i[s]      = rd;
    bus.dec_rs1_i[s]     = rs1;
    bus.dec_rs2_i[s]     = rs2;
    bus.dec_use_rs1_i[s] = u1;
    bus.dec_use_rs2_i[s] = u2;
    bus.dec_long_i[s]    = lng;
    bus.dec_ctrl_i[s]    = ctl;
    if (exp_iss) exp_q.push_back(uid);
  endtask

  task automatic chk(input string tag, input logic e0, input logic e1);
    logic [7:0] ex;
    check({tag, "/v0"}, {31'd0, bus.iss0_v_o}, {31'd0, e0});
    check({tag, "/v1"}, {31'd0, bus.iss1_v_o}, {31'd0, e1});
    if (bus.iss0_v_o) begin
      if (exp_q.size() > 0) ex = exp_q.pop_front();
      else                  ex = 8'hxx;
      check({tag, "/uid0"}, {24'd0, bus.iss0_uid_o}, {24'd0, ex});
    end
    if (bus.iss1_v_o) begin
      if (exp_q.size() > 0) ex = exp_q.pop_front();
      else                  ex = 8'hxx;
      check({tag, "/uid1"}, {24'd0, bus.iss1_uid_o}, {24'd0, ex});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.ex_stall_i = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b0;
    check("rst_v0",   {31'd0, bus.iss0_v_o}, 32'd0);
    check("rst_v1",   {31'd0, bus.iss1_v_o}, 32'd0);
    check("rst_uid0", {24'd0, bus.iss0_uid_o}, 32'd0);
    check("rst_uid1", {24'd0, bus.iss1_uid_o}, 32'd0);
    check("rst_rdy",  {31'd0, bus.dec_rdy_o}, 32'd1);
    check("rst_busy", bus.sb_busy_o, 32'd0);

    // Independent pair dual-issues one cycle after reaching the head.
    put(0, 8'h11, 5'd1, 5'd0, 5'd0, 1, 1, 0, 0, 1);
    put(1, 8'h12, 5'd2, 5'd0, 5'd0, 1, 1, 0, 0, 1);
    tick(); idle();
    chk("pair_lat", 0, 0);
    tick(); chk("pair", 1, 1);
    tick(); chk("pair_empty", 0, 0);
    check("pair_rdy", {31'd0, bus.dec_rdy_o}, 32'd1);

    // Intra-packet RAW splits the pair.
    put(0, 8'h21, 5'd3, 5'd1, 5'd2, 1, 1, 0, 0, 1);
    put(1, 8'h22, 5'd4, 5'd3, 5'd1, 1, 1, 0, 0, 1);
    tick(); idle();
    tick(); chk("raw_n", 1, 0);
    tick(); chk("raw_n1", 1, 0);
    tick(); chk("raw_done", 0, 0);

    // Long-op destination blocks a dependent until writeback.
    put(0, 8'h31, 5'd5, 5'd1, 5'd0, 1, 0, 1, 0, 1);
    put(1, 8'h32, 5'd6, 5'd5, 5'd0, 1, 1, 0, 0, 1);
    tick(); idle();
    tick(); chk("lw_iss", 1, 0);
    check("lw_busy", bus.sb_busy_o, 32'h0000_0020);
    tick(); chk("lw_hold0", 0, 0);
    tick(); chk("lw_hold1", 0, 0);
    bus.wb_v_i = 1'b1; bus.wb_rd_i = 5'd5;
    tick(); idle();
    chk("lw_wb", 0, 0);
    check("lw_clr", bus.sb_busy_o, 32'd0);
    tick(); chk("lw_dep", 1, 0);
    tick(); chk("lw_done", 0, 0);

    // Set and clear of x7 on the same edge: set wins.
    put(0, 8'h41, 5'd7, 5'd1, 5'd0, 1, 0, 1, 0, 1);
    tick(); idle();
    bus.wb_v_i = 1'b1; bus.wb_rd_i = 5'd7;
    tick(); idle();
    chk("sc_iss", 1, 0);
    check("sc_busy", bus.sb_busy_o, 32'h0000_0080);
    bus.wb_v_i = 1'b1; bus.wb_rd_i = 5'd7;
    tick(); idle();
    check("sc_clr", bus.sb_busy_o, 32'd0);

    // Flush with three held uops and a decode pair on the bus.
    put(0, 8'h51, 5'd5, 5'd1, 5'd0, 1, 0, 1, 0, 1);
    tick(); idle();
    tick(); chk("fl_lw", 1, 0);
    put(0, 8'h52, 5'd8, 5'd5, 5'd0, 1, 0, 0, 0, 0);
    put(1, 8'h53, 5'd9, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    tick(); idle();
    put(0, 8'h54, 5'd10, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    tick(); idle();
    check("fl_cnt3_rdy", {31'd0, bus.dec_rdy_o}, 32'd0);
    chk("fl_held", 0, 0);
    bus.flush_i = 1'b1;
    put(0, 8'h55, 5'd11, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    put(1, 8'h56, 5'd12, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    tick(); idle();
    chk("fl_none", 0, 0);
    check("fl_rdy", {31'd0, bus.dec_rdy_o}, 32'd1);
    check("fl_busy", bus.sb_busy_o, 32'h0000_0020);
    bus.wb_v_i = 1'b1; bus.wb_rd_i = 5'd5;
    tick(); idle();
    check("fl_wb", bus.sb_busy_o, 32'd0);
    chk("fl_after_wb", 0, 0);
    tick(); chk("fl_gone", 0, 0);

    // Stall fills the queue; release drains two per cycle in order.
    bus.ex_stall_i = 1'b1;
    put(0, 8'h61, 5'd11, 5'd0, 5'd0, 0, 0, 0, 0, 1);
    put(1, 8'h62, 5'd12, 5'd0, 5'd0, 0, 0, 0, 0, 1);
    tick(); idle();
    check("st_rdy2", {31'd0, bus.dec_rdy_o}, 32'd1);
    chk("st_a", 0, 0);
    put(0, 8'h63, 5'd13, 5'd0, 5'd0, 0, 0, 0, 0, 1);
    put(1, 8'h64, 5'd14, 5'd0, 5'd0, 0, 0, 0, 0, 1);
    tick(); idle();
    check("st_rdy4", {31'd0, bus.dec_rdy_o}, 32'd0);
    chk("st_b", 0, 0);
    put(0, 8'h65, 5'd15, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    put(1, 8'h66, 5'd16, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    tick(); idle();
    chk("st_c", 0, 0);
    check("st_rdy_full", {31'd0, bus.dec_rdy_o}, 32'd0);
    bus.ex_stall_i = 1'b0;
    tick(); chk("st_d", 1, 1);
    check("st_rdy_drain", {31'd0, bus.dec_rdy_o}, 32'd1);
    tick(); chk("st_e", 1, 1);
    tick(); chk("st_f", 0, 0);

    // Control op in lane 0 keeps lane 1 idle.
    put(0, 8'h71, 5'd0, 5'd1, 5'd2, 1, 1, 0, 1, 1);
    put(1, 8'h72, 5'd13, 5'd0, 5'd0, 0, 0, 0, 0, 1);
    tick(); idle();
    tick(); chk("ctl", 1, 0);
    tick(); chk("ctl2", 1, 0);

    // Long op in the younger slot may only go on lane 0.
    put(0, 8'h73, 5'd14, 5'd0, 5'd0, 0, 0, 0, 0, 1);
    put(1, 8'h74, 5'd15, 5'd1, 5'd0, 1, 0, 1, 0, 1);
    tick(); idle();
    tick(); chk("l1long", 1, 0);
    tick(); chk("l1long2", 1, 0);
    check("l1long_busy", bus.sb_busy_o, 32'h0000_8000);
    bus.wb_v_i = 1'b1; bus.wb_rd_i = 5'd15;
    tick(); idle();
    check("l1long_clr", bus.sb_busy_o, 32'd0);

    // rd=x0 never creates a RAW dependency.
    put(0, 8'h81, 5'd0, 5'd1, 5'd0, 1, 0, 0, 0, 1);
    put(1, 8'h82, 5'd16, 5'd0, 5'd0, 1, 1, 0, 0, 1);
    tick(); idle();
    tick(); chk("x0", 1, 1);

    // Reset mid-operation drops queue and scoreboard.
    put(0, 8'h91, 5'd13, 5'd1, 5'd0, 1, 0, 1, 0, 1);
    tick(); idle();
    tick(); chk("rm_lw", 1, 0);
    check("rm_busy", bus.sb_busy_o, 32'h0000_2000);
    bus.ex_stall_i = 1'b1;
    put(0, 8'h92, 5'd17, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    put(1, 8'h93, 5'd18, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    tick(); idle();
    rst = 1'b1;
    bus.ex_stall_i = 1'b0;
    tick();
    rst = 1'b0;
    chk("rm_out", 0, 0);
    check("rm_sb", bus.sb_busy_o, 32'd0);
    check("rm_rdy", {31'd0, bus.dec_rdy_o}, 32'd1);
    tick(); chk("rm_q", 0, 0);

    check("exp_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
